// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: merges the execute (A) and memory (B)
// writeback streams onto one registered write port, round-robin with a same-register override.
module regfile_wb_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 8,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aValid,
  input  logic [AW-1:0]    aAddr,
  input  logic [WIDTH-1:0] aData,
  output logic             aReady,
  input  logic             bValid,
  input  logic [AW-1:0]    bAddr,
  input  logic [WIDTH-1:0] bData,
  output logic             bReady,
  output logic             write,
  output logic [AW-1:0]    wrAddr,
  output logic [WIDTH-1:0] wrData,
  output logic [SIZE-1:0]  pendMask
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  src_t             last_grant;
  logic             same_addr;
  logic             grant_a;
  logic             grant_b;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic             sel_is_r0;
  logic [SIZE-1:0]  pend_next;

  // B is the older instruction, so on a same-register clash it goes first and A lands last.
  always_comb begin
    same_addr = aValid && bValid && (aAddr == bAddr);
    grant_a   = !rst && aValid && (!bValid || (!same_addr && last_grant == SRC_B));
    grant_b   = !rst && bValid && (!aValid || same_addr || last_grant == SRC_A);
    aReady    = grant_a;
    bReady    = grant_b;
    sel_addr  = grant_a ? aAddr : bAddr;
    sel_data  = grant_a ? aData : bData;
    sel_is_r0 = (ZERO_R0 != 0) && (sel_addr == '0);
  end

  always_comb begin
    pend_next = '0;
    for (int i = 0; i < SIZE; i++) begin
      pend_next[i] = (aValid && !aReady && (aAddr == AW'(i))) ||
                     (bValid && !bReady && (bAddr == AW'(i)));
    end
  end

  // Writes to r0 are still acknowledged but never reach the register file when it is hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write      <= 1'b0;
      wrAddr     <= '0;
      wrData     <= '0;
      pendMask   <= '0;
      last_grant <= SRC_B;
    end else begin
      pendMask <= pend_next;
      write    <= 1'b0;
      if (grant_a || grant_b) begin
        wrAddr     <= sel_addr;
        wrData     <= sel_data;
        write      <= !sel_is_r0;
        last_grant <= grant_a ? SRC_A : SRC_B;
      end
    end
  end

endmodule
